// File: rtl/spi_sram_wb_bridge_if.sv
// Wishbone B4 classic single-byte bus between the Levenshtein controller and
// the serial-SRAM bridge; signal names match the legacy bridge ports.
interface spi_sram_wb_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 24
);
  logic                  wbs_cyc_i;
  logic                  wbs_stb_i;
  logic [ADDR_WIDTH-1:0] wbs_adr_i;
  logic                  wbs_we_i;
  logic [7:0]            wbs_dat_i;
  logic                  wbs_ack_o;
  logic                  wbs_err_o;
  logic                  wbs_rty_o;
  logic [7:0]            wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_adr_i, wbs_we_i, wbs_dat_i,
    input  wbs_ack_o, wbs_err_o, wbs_rty_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_adr_i, wbs_we_i, wbs_dat_i,
    output wbs_ack_o, wbs_err_o, wbs_rty_o, wbs_dat_o
  );
endinterface

// File: rtl/spi_sram_wb_bridge.sv
// Wishbone slave turning single-byte cycles into 40-bit SPI mode-0 frames
// ({cmd, addr24, data}) on a 23LC1024-class sequential-mode serial SRAM.
module spi_sram_wb_bridge #(
  parameter int unsigned ADDR_WIDTH = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  spi_sram_wb_bridge_if.slave   wbs,
  output logic                  spi_cs_n_o,
  output logic                  spi_sck_o,
  output logic                  spi_mosi_o,
  input  logic                  spi_miso_i
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  logic [1:0]  state_q,   state_d;
  logic [39:0] shift_q,   shift_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic        phase_q,   phase_d;
  logic        cs_n_q,    cs_n_d;
  logic        sck_q,     sck_d;
  logic        we_q,      we_d;
  logic        ack_q,     ack_d;
  logic [7:0]  dat_q,     dat_d;

  logic [23:0] adr24;
  logic        req;

  always_comb begin
    adr24 = 24'(wbs.wbs_adr_i);
    req   = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q;
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    cs_n_d    = cs_n_q;
    sck_d     = sck_q;
    we_d      = we_q;
    ack_d     = ack_q;
    dat_d     = dat_q;

    case (state_q)
      IDLE: begin
        ack_d  = 1'b0;
        sck_d  = 1'b0;
        cs_n_d = 1'b1;
        if (req) begin
          shift_d   = {(wbs.wbs_we_i ? CMD_WRITE : CMD_READ), adr24,
                       (wbs.wbs_we_i ? wbs.wbs_dat_i : 8'h00)};
          bit_cnt_d = 6'd39;
          phase_d   = 1'b0;
          cs_n_d    = 1'b0;
          we_d      = wbs.wbs_we_i;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (!phase_q) begin
          sck_d   = 1'b1;
          phase_d = 1'b1;
        end else begin
          // MISO is captured on the edge that drops SCK, i.e. while SCK was high.
          sck_d     = 1'b0;
          shift_d   = {shift_q[38:0], spi_miso_i};
          bit_cnt_d = bit_cnt_q - 6'd1;
          phase_d   = 1'b0;
          if (bit_cnt_q == 6'd0) begin
            // Frame always completes; an abandoned cycle just gets no ack.
            state_d = ACK;
            cs_n_d  = 1'b1;
            ack_d   = wbs.wbs_cyc_i;
            if (!we_q) begin
              dat_d = {shift_q[6:0], spi_miso_i};
            end
          end
        end
      end

      ACK: begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
        cs_n_d  = 1'b1;
        sck_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      phase_q   <= 1'b0;
      cs_n_q    <= 1'b1;
      sck_q     <= 1'b0;
      we_q      <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      cs_n_q    <= cs_n_d;
      sck_q     <= sck_d;
      we_q      <= we_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
    end
  end

  always_comb begin
    spi_cs_n_o = cs_n_q;
    spi_sck_o  = sck_q;
    spi_mosi_o = (state_q == SHIFT) ? shift_q[39] : 1'b0;
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign wbs.wbs_err_o = 1'b0;
  assign wbs.wbs_rty_o = 1'b0;

endmodule

// File: tb/tb_spi_sram_wb_bridge.sv
// Directed bench for spi_sram_wb_bridge with a behavioural 23LC1024 model.
module tb_spi_sram_wb_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_sram_wb_bridge_if #(.ADDR_WIDTH(24)) wb ();
  spi_sram_wb_bridge_if #(.ADDR_WIDTH(17)) wb17 ();

  logic cs_n, sck, mosi;
  logic miso = 1'b0;
  logic cs17, sck17, mosi17;
  logic miso17 = 1'b1;

  spi_sram_wb_bridge #(.ADDR_WIDTH(24)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wbs(wb.slave),
    .spi_cs_n_o(cs_n), .spi_sck_o(sck), .spi_mosi_o(mosi), .spi_miso_i(miso)
  );

  spi_sram_wb_bridge #(.ADDR_WIDTH(17)) dut17 (
    .clk_i(clk), .rst_ni(rst_n), .wbs(wb17.slave),
    .spi_cs_n_o(cs17), .spi_sck_o(sck17), .spi_mosi_o(mosi17), .spi_miso_i(miso17)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // Serial SRAM model
  logic [7:0]  mem [int unsigned];
  logic [39:0] m_frame = '0;
  logic [39:0] last_frame = '0;
  logic [7:0]  rd_byte = '0;
  int m_cnt = 0;
  int m_idx = 0;
  int frames = 0;
  int sck_rises = 0;

  always @(negedge cs_n) begin
    m_cnt = 0;
    m_frame = '0;
  end

  always @(posedge sck) if (cs_n === 1'b0) begin
    m_frame = {m_frame[38:0], mosi};
    m_cnt++;
    sck_rises++;
  end

  always @(negedge sck) if (cs_n === 1'b0) begin
    if (m_cnt == 32 && m_frame[31:24] == 8'h03)
      rd_byte = mem.exists(int'(m_frame[23:0])) ? mem[int'(m_frame[23:0])] : 8'h00;
    if (m_cnt >= 32 && m_cnt < 40) begin
      m_idx = 39 - m_cnt;
      miso = rd_byte[m_idx];
    end else begin
      miso = 1'($urandom_range(1, 0));
    end
  end

  always @(posedge cs_n) begin
    if (m_cnt == 40) begin
      last_frame = m_frame;
      frames++;
      if (m_frame[39:32] == 8'h02) mem[int'(m_frame[31:8])] = m_frame[7:0];
    end
  end

  // Narrow-address instance: capture frame only
  logic [39:0] frame17 = '0;
  always @(negedge cs17) frame17 = '0;
  always @(posedge sck17) if (cs17 === 1'b0) frame17 = {frame17[38:0], mosi17};

  // Bus-side monitors sampled mid-cycle
  int cs_low_cnt = 0;
  int hi_run = 0;
  int last_gap = 0;
  int ack_cnt = 0;
  always @(negedge clk) begin
    if (cs_n === 1'b0) begin
      cs_low_cnt++;
      if (hi_run > 0) last_gap = hi_run;
      hi_run = 0;
    end else begin
      hi_run++;
    end
    if (wb.wbs_ack_o === 1'b1) ack_cnt++;
  end

  task automatic start_req(input logic [23:0] a, input logic w, input logic [7:0] d);
    @(negedge clk);
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_adr_i = a;
    wb.wbs_we_i  = w;
    wb.wbs_dat_i = d;
  endtask

  task automatic end_req();
    @(negedge clk);
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
  endtask

  task automatic wait_ack(output int cycles, output bit seen);
    cycles = 0;
    seen = 1'b0;
    while (!seen && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
      if (wb.wbs_ack_o === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic do_xfer(input logic [23:0] a, input logic w, input logic [7:0] d,
                         output int cycles, output bit seen, output logic ack_after);
    start_req(a, w, d);
    wait_ack(cycles, seen);
    end_req();
    @(posedge clk);
    #1;
    ack_after = wb.wbs_ack_o;
  endtask

  task automatic test_reset();
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_adr_i = '0;
    wb.wbs_we_i = 1'b0;  wb.wbs_dat_i = '0;
    wb17.wbs_cyc_i = 1'b0; wb17.wbs_stb_i = 1'b0; wb17.wbs_adr_i = '0;
    wb17.wbs_we_i = 1'b0;  wb17.wbs_dat_i = '0;
    rst_n = 1'b0;
    #22;
    total_cnt++; if (wb.wbs_ack_o !== 1'b0) $display("FAIL reset_ack got=%b exp=0", wb.wbs_ack_o); else pass_cnt++;
    total_cnt++; if (wb.wbs_dat_o !== 8'h00) $display("FAIL reset_dat got=%h exp=00", wb.wbs_dat_o); else pass_cnt++;
    total_cnt++; if (cs_n !== 1'b1) $display("FAIL reset_cs_n got=%b exp=1", cs_n); else pass_cnt++;
    total_cnt++; if (sck !== 1'b0) $display("FAIL reset_sck got=%b exp=0", sck); else pass_cnt++;
    total_cnt++; if (mosi !== 1'b0) $display("FAIL reset_mosi got=%b exp=0", mosi); else pass_cnt++;
    total_cnt++; if (wb.wbs_err_o !== 1'b0 || wb.wbs_rty_o !== 1'b0)
      $display("FAIL reset_err_rty got=%b%b exp=00", wb.wbs_err_o, wb.wbs_rty_o); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (cs_n !== 1'b1) $display("FAIL idle_cs_n got=%b exp=1", cs_n); else pass_cnt++;
  endtask

  task automatic test_read();
    int cyc; bit seen; logic aa; int s0;
    mem[32'h800001] = 8'hA5;
    s0 = sck_rises;
    cs_low_cnt = 0;
    do_xfer(24'h800001, 1'b0, 8'h00, cyc, seen, aa);
    total_cnt++; if (!seen) $display("FAIL read_ack_seen got=0 exp=1"); else pass_cnt++;
    total_cnt++; if (cyc != 81) $display("FAIL read_latency got=%0d exp=81", cyc); else pass_cnt++;
    total_cnt++; if (last_frame !== {8'h03, 24'h800001, 8'h00})
      $display("FAIL read_mosi got=%h exp=0380000100", last_frame); else pass_cnt++;
    total_cnt++; if (sck_rises - s0 != 40) $display("FAIL read_sck_pulses got=%0d exp=40", sck_rises - s0); else pass_cnt++;
    total_cnt++; if (wb.wbs_dat_o !== 8'hA5) $display("FAIL read_data got=%h exp=a5", wb.wbs_dat_o); else pass_cnt++;
    total_cnt++; if (cs_low_cnt != 80) $display("FAIL read_cs_low got=%0d exp=80", cs_low_cnt); else pass_cnt++;
    total_cnt++; if (aa !== 1'b0) $display("FAIL read_ack_width got=%b exp=0", aa); else pass_cnt++;
  endtask

  task automatic test_write();
    int cyc; bit seen; logic aa; int s0;
    s0 = sck_rises;
    do_xfer(24'h000102, 1'b1, 8'h3C, cyc, seen, aa);
    total_cnt++; if (!seen || cyc != 81) $display("FAIL write_latency got=%0d seen=%b exp=81", cyc, seen); else pass_cnt++;
    total_cnt++; if (last_frame !== {8'h02, 24'h000102, 8'h3C})
      $display("FAIL write_mosi got=%h exp=020001023c", last_frame); else pass_cnt++;
    total_cnt++; if (sck_rises - s0 != 40) $display("FAIL write_sck_pulses got=%0d exp=40", sck_rises - s0); else pass_cnt++;
    total_cnt++; if (wb.wbs_dat_o !== 8'hA5) $display("FAIL write_keeps_dat got=%h exp=a5", wb.wbs_dat_o); else pass_cnt++;
    total_cnt++; if (aa !== 1'b0) $display("FAIL write_ack_width got=%b exp=0", aa); else pass_cnt++;
    do_xfer(24'h000102, 1'b0, 8'h00, cyc, seen, aa);
    total_cnt++; if (!seen || wb.wbs_dat_o !== 8'h3C)
      $display("FAIL readback_data got=%h seen=%b exp=3c", wb.wbs_dat_o, seen); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int c1, c2, f0; bit s1, s2; logic [7:0] d1, d2; logic a1;
    mem[32'h000000] = 8'h11;
    mem[32'h000001] = 8'h22;
    f0 = frames;
    start_req(24'h000000, 1'b0, 8'h00);
    wait_ack(c1, s1);
    d1 = wb.wbs_dat_o;
    wb.wbs_adr_i = 24'h000001;
    @(posedge clk);
    #1;
    a1 = wb.wbs_ack_o;
    wait_ack(c2, s2);
    d2 = wb.wbs_dat_o;
    end_req();
    @(posedge clk);
    #1;
    total_cnt++; if (!s1 || c1 != 81) $display("FAIL b2b_first_latency got=%0d seen=%b exp=81", c1, s1); else pass_cnt++;
    total_cnt++; if (d1 !== 8'h11) $display("FAIL b2b_first_data got=%h exp=11", d1); else pass_cnt++;
    total_cnt++; if (a1 !== 1'b0) $display("FAIL b2b_ack_width got=%b exp=0", a1); else pass_cnt++;
    total_cnt++; if (!s2 || c2 != 81) $display("FAIL b2b_second_latency got=%0d seen=%b exp=81", c2, s2); else pass_cnt++;
    total_cnt++; if (d2 !== 8'h22) $display("FAIL b2b_second_data got=%h exp=22", d2); else pass_cnt++;
    total_cnt++; if (frames - f0 != 2) $display("FAIL b2b_frames got=%0d exp=2", frames - f0); else pass_cnt++;
    total_cnt++; if (last_gap != 2) $display("FAIL b2b_cs_gap got=%0d exp=2", last_gap); else pass_cnt++;
  endtask

  task automatic test_abort();
    int a0, f0, cyc; bit seen; logic aa;
    mem[32'h000200] = 8'h5A;
    f0 = frames;
    a0 = ack_cnt;
    cs_low_cnt = 0;
    start_req(24'h000200, 1'b0, 8'h00);
    @(posedge clk);
    repeat (20) @(posedge clk);
    @(negedge clk);
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_adr_i = 24'h000999;
    wb.wbs_we_i  = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    total_cnt++; if (ack_cnt != a0) $display("FAIL abort_no_ack got=%0d exp=0", ack_cnt - a0); else pass_cnt++;
    total_cnt++; if (cs_low_cnt != 80) $display("FAIL abort_cs_low got=%0d exp=80", cs_low_cnt); else pass_cnt++;
    total_cnt++; if (frames - f0 != 1) $display("FAIL abort_frame_done got=%0d exp=1", frames - f0); else pass_cnt++;
    total_cnt++; if (last_frame !== {8'h03, 24'h000200, 8'h00})
      $display("FAIL abort_mosi got=%h exp=0300020000", last_frame); else pass_cnt++;
    do_xfer(24'h800001, 1'b0, 8'h00, cyc, seen, aa);
    total_cnt++; if (!seen || cyc != 81 || wb.wbs_dat_o !== 8'hA5)
      $display("FAIL abort_next_req got=%0d/%h seen=%b exp=81/a5", cyc, wb.wbs_dat_o, seen); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int cyc; bit seen; logic aa; logic pre_sck;
    mem[32'h7FFFFF] = 8'hC3;
    start_req(24'h000300, 1'b1, 8'h77);
    @(posedge clk);
    repeat (37) @(posedge clk);
    #2;
    pre_sck = sck;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (pre_sck !== 1'b1) $display("FAIL rstmid_pre_sck got=%b exp=1", pre_sck); else pass_cnt++;
    total_cnt++; if (cs_n !== 1'b1) $display("FAIL rstmid_cs_n got=%b exp=1", cs_n); else pass_cnt++;
    total_cnt++; if (sck !== 1'b0) $display("FAIL rstmid_sck got=%b exp=0", sck); else pass_cnt++;
    total_cnt++; if (wb.wbs_ack_o !== 1'b0) $display("FAIL rstmid_ack got=%b exp=0", wb.wbs_ack_o); else pass_cnt++;
    total_cnt++; if (wb.wbs_dat_o !== 8'h00) $display("FAIL rstmid_dat got=%h exp=00", wb.wbs_dat_o); else pass_cnt++;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_xfer(24'h7FFFFF, 1'b0, 8'h00, cyc, seen, aa);
    total_cnt++; if (!seen || cyc != 81) $display("FAIL rstmid_read_latency got=%0d seen=%b exp=81", cyc, seen); else pass_cnt++;
    total_cnt++; if (last_frame !== {8'h03, 24'h7FFFFF, 8'h00})
      $display("FAIL rstmid_read_mosi got=%h exp=037fffff00", last_frame); else pass_cnt++;
    total_cnt++; if (wb.wbs_dat_o !== 8'hC3) $display("FAIL rstmid_read_data got=%h exp=c3", wb.wbs_dat_o); else pass_cnt++;
  endtask

  task automatic test_addr17();
    int cyc; bit seen;
    @(negedge clk);
    wb17.wbs_cyc_i = 1'b1;
    wb17.wbs_stb_i = 1'b1;
    wb17.wbs_adr_i = 17'h1FFFF;
    wb17.wbs_we_i  = 1'b0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (wb17.wbs_ack_o === 1'b1) seen = 1'b1;
    end
    @(negedge clk);
    wb17.wbs_cyc_i = 1'b0;
    wb17.wbs_stb_i = 1'b0;
    total_cnt++; if (!seen || cyc != 81) $display("FAIL aw17_latency got=%0d seen=%b exp=81", cyc, seen); else pass_cnt++;
    total_cnt++; if (frame17[39:8] !== {8'h03, 24'h01FFFF})
      $display("FAIL aw17_cmd_addr got=%h exp=0301ffff", frame17[39:8]); else pass_cnt++;
    total_cnt++; if (wb17.wbs_dat_o !== 8'hFF) $display("FAIL aw17_data got=%h exp=ff", wb17.wbs_dat_o); else pass_cnt++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_addr17();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
